m_user_input_encoder: RTL and testbench

//  Producer side of the 2-bit user-input code consumed by the manual-play controller.

---
 rtl/m_user_input_encoder_pkg.sv | 22 ++
 rtl/m_user_input_encoder_if.sv | 11 +
 rtl/m_user_input_encoder_debouncer.sv | 47 ++++
 rtl/m_user_input_encoder.sv | 134 +++++++++++++
 tb/tb_m_user_input_encoder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/m_user_input_encoder_pkg.sv
// Shared event codes, button indices and repeat-FSM states for the user-input encoder.
package m_user_input_encoder_pkg;

  // NONE is all-ones because INC already owns the all-zero code.
  typedef enum logic [1:0] {
    UI_INC  = 2'b00,
    UI_DEC  = 2'b01,
    UI_OK   = 2'b10,
    UI_NONE = 2'b11
  } user_code_e;

  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_OK  = 2;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_REPEAT
  } rep_state_e;

endpackage

// File: rtl/m_user_input_encoder_if.sv
// Button inputs and event/status outputs of the encoder; master is the encoder side.
interface m_user_input_encoder_if;
  logic       i_btn_inc;
  logic       i_btn_dec;
  logic       i_btn_ok;
  logic [1:0] o_user_input;
  logic [2:0] o_pending;

  modport master (input i_btn_inc, i_btn_dec, i_btn_ok, output o_user_input, o_pending);
  modport slave  (output i_btn_inc, i_btn_dec, i_btn_ok, input o_user_input, o_pending);
endinterface

// File: rtl/m_user_input_encoder_debouncer.sv
// Two-flop synchroniser, debounce counter and stable level for one raw button, plus a press pulse.
module m_debouncer #(
  parameter int unsigned CYCLES = 100000
) (
  input  logic w_clk,
  input  logic w_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: non-blocking assignments so every flop here samples the pre-edge values of the others.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_rise <= 1'b0;
      if (r_sync[1] != r_level) begin
        // The CYCLES-th consecutive mismatch flips the level; any agreeing cycle restarts the count.
        if (r_cnt == CNT_W'(CYCLES - 1)) begin
          r_level <= r_sync[1];
          r_rise  <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/m_user_input_encoder.sv
// Debounced INC/DEC/OK buttons to spaced one-cycle event codes (OK > INC > DEC).
// Optional INC/DEC auto-repeat is built only when AUTO_REPEAT_EN is defined.
module m_user_input_encoder
  import m_user_input_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES      = 1,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input logic                    w_clk,
  input logic                    w_rst,
  m_user_input_encoder_if.master if_bus
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  if (DEBOUNCE_CYCLES == 0 || GAP_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
    $error("m_user_input_encoder: timing parameters must all be at least 1");
  end

  logic [2:0] w_raw, w_level, w_rise, w_rep_set, w_set, w_grant;
  user_code_e w_code, r_user_input;
  logic [2:0] r_pending;
  logic [GAP_W-1:0] r_gap_cnt;

  assign w_raw = {if_bus.i_btn_ok, if_bus.i_btn_dec, if_bus.i_btn_inc};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    m_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .w_clk  (w_clk),
      .w_rst  (w_rst),
      .i_raw  (w_raw[b]),
      .o_level(w_level[b]),
      .o_rise (w_rise[b])
    );
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  rep_state_e       r_rep_state, w_rep_state_nxt;
  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic             r_rep_sel, w_rep_sel_nxt;  // 0 = INC held, 1 = DEC held
  logic             w_one_held;

  assign w_one_held = w_level[BTN_INC] ^ w_level[BTN_DEC];

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_rep_state <= REP_IDLE;
      r_rep_cnt   <= '0;
      r_rep_sel   <= 1'b0;
    end else begin
      r_rep_state <= w_rep_state_nxt;
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_sel   <= w_rep_sel_nxt;
    end
  end

  // Count value 0 is itself the expiry cycle, so the periodic reload is one short of the period.
  always_comb begin
    w_rep_state_nxt = r_rep_state;
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_sel_nxt   = r_rep_sel;
    w_rep_set       = '0;
    case (r_rep_state)
      REP_IDLE: begin
        if (w_one_held) begin
          w_rep_state_nxt = REP_DELAY;
          w_rep_cnt_nxt   = REP_W'(REPEAT_DELAY);
          w_rep_sel_nxt   = w_level[BTN_DEC];
        end
      end
      REP_DELAY, REP_REPEAT: begin
        if (!w_one_held || (w_level[BTN_DEC] != r_rep_sel)) begin
          w_rep_state_nxt = REP_IDLE;
        end else if (r_rep_cnt == '0) begin
          w_rep_state_nxt = REP_REPEAT;
          w_rep_cnt_nxt   = REP_W'(REPEAT_PERIOD - 1);
          w_rep_set       = r_rep_sel ? 3'b010 : 3'b001;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt - REP_W'(1);
        end
      end
      default: w_rep_state_nxt = REP_IDLE;
    endcase
  end
`else
  assign w_rep_set = '0;
`endif

  assign w_set = w_rise | w_rep_set;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    w_grant = '0;
    w_code  = UI_NONE;
    if (r_gap_cnt == '0) begin
      if (r_pending[BTN_OK]) begin
        w_grant[BTN_OK] = 1'b1;
        w_code          = UI_OK;
      end else if (r_pending[BTN_INC]) begin
        w_grant[BTN_INC] = 1'b1;
        w_code           = UI_INC;
      end else if (r_pending[BTN_DEC]) begin
        w_grant[BTN_DEC] = 1'b1;
        w_code           = UI_DEC;
      end
    end
  end

  // A new press on the bit being granted wins over the clear, so it is not lost.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_user_input <= UI_NONE;
      r_pending    <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_user_input <= w_code;
      r_pending    <= (r_pending & ~w_grant) | w_set;
      if (|w_grant) begin
        r_gap_cnt <= GAP_W'(GAP_CYCLES);
      end else if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  assign if_bus.o_user_input = r_user_input;
  assign if_bus.o_pending    = r_pending;

endmodule

// File: tb/tb_m_user_input_encoder.sv
// Directed and random checks of m_user_input_encoder against a behavioural reference model.
module tb_m_user_input_encoder;

  localparam int DB  = 4;
  localparam int GAP = 1;
  localparam int RD  = 20;
  localparam int RP  = 8;

  typedef struct {
    int         e;
    logic [1:0] c;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_no = 0;
  int   last_edge = 0;
  ev_t  ev_q[$];

  m_user_input_encoder_if u_if ();

  m_user_input_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .GAP_CYCLES     (GAP),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .w_clk (clk),
    .w_rst (rst),
    .if_bus(u_if)
  );

  always #5 clk = ~clk;

  // Reference model state: delayed input, debounced level, mismatch run length per button.
  bit         m_s1[3], m_s2[3], m_lvl[3], m_rise[3];
  int         m_run[3];
  bit   [2:0] m_pend = '0;
  int         m_gap = 0;
  logic [1:0] m_out = 2'b11;
`ifdef AUTO_REPEAT_EN
  int m_age  = 0;   // consecutive cycles a single INC/DEC level has been held
  int m_held = -1;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit raw[3];
    bit [2:0] set;
`ifdef AUTO_REPEAT_EN
    int now;
`endif
    raw[0] = u_if.i_btn_inc;
    raw[1] = u_if.i_btn_dec;
    raw[2] = u_if.i_btn_ok;
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_rise[b] = 0; m_run[b] = 0;
      end
      m_pend = '0;
      m_gap  = 0;
      m_out  = 2'b11;
`ifdef AUTO_REPEAT_EN
      m_age  = 0;
      m_held = -1;
`endif
      return;
    end
    set = {m_rise[2], m_rise[1], m_rise[0]};
`ifdef AUTO_REPEAT_EN
    now = (m_lvl[0] != m_lvl[1]) ? (m_lvl[1] ? 1 : 0) : -1;
    if (now < 0 || (m_held >= 0 && now != m_held)) m_age = 0;
    else m_age++;
    m_held = now;
    if (now >= 0 && (m_age == RD + 2 || (m_age > RD + 2 && (m_age - RD - 2) % RP == 0)))
      set[now] = 1'b1;
`endif
    if (m_gap == 0 && m_pend != 0) begin
      if (m_pend[2])      begin m_out = 2'b10; m_pend[2] = 0; end
      else if (m_pend[0]) begin m_out = 2'b00; m_pend[0] = 0; end
      else                begin m_out = 2'b01; m_pend[1] = 0; end
      m_gap = GAP;
    end else begin
      m_out = 2'b11;
      if (m_gap > 0) m_gap--;
    end
    m_pend |= set;
    for (int b = 0; b < 3; b++) begin
      m_rise[b] = 0;
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_lvl[b]  = m_s2[b];
          m_rise[b] = m_s2[b];
          m_run[b]  = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    last_edge = edge_no;
    edge_no++;
    @(negedge clk);
    check({tag, "_code"}, 32'(u_if.o_user_input), 32'(m_out));
    check({tag, "_pend"}, 32'(u_if.o_pending), 32'(m_pend));
    if (u_if.o_user_input !== 2'b11) ev_q.push_back('{last_edge, u_if.o_user_input});
  endtask

  task automatic set_btns(input logic inc, input logic dec, input logic ok);
    u_if.i_btn_inc = inc;
    u_if.i_btn_dec = dec;
    u_if.i_btn_ok  = ok;
  endtask

  initial begin
    int t0;
    int exp5[$];
    int rem[3];
    logic lv[3];

    // 1: reset with buttons idle
    rst = 1'b1;
    set_btns(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("t1_rst");
      check("t1_rst_code_const", 32'(u_if.o_user_input), 32'h3);
      check("t1_rst_pend_const", 32'(u_if.o_pending), 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step("t1_idle");
    check("t1_idle_code_const", 32'(u_if.o_user_input), 32'h3);

    // 2: three-cycle glitch is ignored
    ev_q.delete();
    set_btns(1, 0, 0);
    for (int i = 0; i < 3; i++) step("t2");
    set_btns(0, 0, 0);
    for (int i = 0; i < 12; i++) step("t2");
    check("t2_no_event", 32'(ev_q.size()), 32'd0);

    // 3: clean INC press, single event D+3 edges after first sample
    ev_q.delete();
    t0 = edge_no;
    set_btns(1, 0, 0);
    for (int i = 0; i < 15; i++) step("t3");
    set_btns(0, 0, 0);
    for (int i = 0; i < 15; i++) step("t3");
    check("t3_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() >= 1) begin
      check("t3_edge", 32'(ev_q[0].e - t0), 32'd7);
      check("t3_code", 32'(ev_q[0].c), 32'h0);
    end

    // 4: INC and OK together -> OK, one NONE, INC
    ev_q.delete();
    t0 = edge_no;
    set_btns(1, 0, 1);
    for (int i = 0; i < 15; i++) step("t4");
    set_btns(0, 0, 0);
    for (int i = 0; i < 15; i++) step("t4");
    check("t4_count", 32'(ev_q.size()), 32'd2);
    if (ev_q.size() >= 2) begin
      check("t4_edge0", 32'(ev_q[0].e - t0), 32'd7);
      check("t4_code0", 32'(ev_q[0].c), 32'h2);
      check("t4_edge1", 32'(ev_q[1].e - t0), 32'd9);
      check("t4_code1", 32'(ev_q[1].c), 32'h0);
    end

    // 5: DEC held 60 cycles
    ev_q.delete();
`ifdef AUTO_REPEAT_EN
    exp5 = '{7, 28, 36, 44, 52, 60};
`else
    exp5 = '{7};
`endif
    t0 = edge_no;
    set_btns(0, 1, 0);
    for (int i = 0; i < 60; i++) step("t5");
    set_btns(0, 0, 0);
    for (int i = 0; i < 20; i++) step("t5");
    check("t5_count", 32'(ev_q.size()), 32'(exp5.size()));
    for (int i = 0; i < exp5.size() && i < ev_q.size(); i++) begin
      check($sformatf("t5_edge%0d", i), 32'(ev_q[i].e - t0), 32'(exp5[i]));
      check($sformatf("t5_code%0d", i), 32'(ev_q[i].c), 32'h1);
    end

    // 6: reset the cycle before an OK would be emitted
    ev_q.delete();
    set_btns(0, 0, 1);
    for (int i = 0; i < 7; i++) step("t6");
    check("t6_pend_set", 32'(u_if.o_pending), 32'h4);
    rst = 1'b1;
    set_btns(0, 0, 0);
    step("t6_rst");
    check("t6_rst_code", 32'(u_if.o_user_input), 32'h3);
    check("t6_rst_pend", 32'(u_if.o_pending), 32'h0);
    step("t6_rst");
    rst = 1'b0;
    for (int i = 0; i < 15; i++) step("t6");
    check("t6_no_event", 32'(ev_q.size()), 32'd0);

    // Random: mixed glitches, presses, long holds and occasional resets
    for (int b = 0; b < 3; b++) begin
      rem[b] = 0;
      lv[b]  = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lv[b]  = $urandom_range(0, 1);
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 12);
        end
        rem[b]--;
      end
      set_btns(lv[0], lv[1], lv[2]);
      rst = ($urandom_range(0, 299) == 0);
      step("rnd");
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
